// File: rtl/sd_burst_rrmux.sv
// Round-robin srdy/drdy multiplexer with a per-grant burst limit and one registered
// output stage; p_grant tags each output word with the requester that supplied it.
module sd_burst_rrmux #(
    parameter int width     = 8,
    parameter int inputs    = 4,
    parameter int max_burst = 4,
    localparam int iw       = $clog2(inputs)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [inputs-1:0]       c_srdy,
    output logic [inputs-1:0]       c_drdy,
    input  logic [inputs*width-1:0] c_data,
    output logic                    p_srdy,
    input  logic                    p_drdy,
    output logic [width-1:0]        p_data,
    output logic [iw-1:0]           p_grant
);

    localparam int bw = $clog2(max_burst + 1);
    localparam logic [inputs-1:0] lsb_only  = {{(inputs-1){1'b0}}, 1'b1};
    localparam logic [bw-1:0]     burst_max = bw'(max_burst);

    logic [iw-1:0]     cur_r;
    logic [bw-1:0]     burst_cnt_r;
    logic              p_srdy_r;
    logic [width-1:0]  p_data_r;
    logic [iw-1:0]     p_grant_r;

    logic              load_s;
    logic              others_s;
    logic              stay_s;
    logic              rot_found_s;
    logic [iw-1:0]     rot_idx_s;
    logic              win_valid_s;
    logic [iw-1:0]     win_idx_s;
    logic [inputs-1:0] cur_mask_s;
    logic [inputs-1:0] win_mask_s;
    logic [width-1:0]  win_data_s;
    logic [bw-1:0]     burst_next_s;
    logic              xfer_s;

    // Winner selection: keep the current grant while it has burst credit, else rotate.
    always_comb begin
        int   idx_v;
        logic hit_v;
        idx_v       = 0;
        hit_v       = 1'b0;
        load_s      = !p_srdy_r || p_drdy;
        cur_mask_s  = lsb_only << cur_r;
        others_s    = |(c_srdy & ~cur_mask_s);
        // burst_cnt_r == 0 only after reset: no grant is held yet, so scanning starts at 0
        stay_s      = c_srdy[cur_r] && (burst_cnt_r != {bw{1'b0}}) &&
                      ((burst_cnt_r < burst_max) || !others_s);
        rot_found_s = 1'b0;
        rot_idx_s   = cur_r;
        for (int i = 1; i <= inputs; i++) begin
            idx_v       = (int'(cur_r) + i >= inputs) ? int'(cur_r) + i - inputs : int'(cur_r) + i;
            hit_v       = !rot_found_s && c_srdy[iw'(idx_v)];
            rot_idx_s   = hit_v ? iw'(idx_v) : rot_idx_s;
            rot_found_s = rot_found_s | hit_v;
        end
        if (stay_s) begin
            win_valid_s = 1'b1;
            win_idx_s   = cur_r;
        end else begin
            win_valid_s = rot_found_s;
            win_idx_s   = rot_idx_s;
        end
        win_mask_s = lsb_only << win_idx_s;
        xfer_s     = win_valid_s && load_s;
    end

    // Data select and burst-count update for the selected requester.
    always_comb begin
        win_data_s = {width{1'b0}};
        for (int k = 0; k < inputs; k++) begin
            win_data_s = win_data_s | (c_data[k*width +: width] & {width{win_mask_s[k]}});
        end
        if (win_idx_s != cur_r) begin
            burst_next_s = bw'(1'b1);
        end else if (burst_cnt_r == burst_max) begin
            burst_next_s = burst_cnt_r;
        end else begin
            burst_next_s = burst_cnt_r + bw'(1'b1);
        end
        if (xfer_s && reset_n) begin
            c_drdy = win_mask_s;
        end else begin
            c_drdy = {inputs{1'b0}};
        end
    end

    // Output stage and arbitration state; idle cycles keep cur/burst credit intact.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_srdy_r    <= 1'b0;
            p_data_r    <= {width{1'b0}};
            p_grant_r   <= {iw{1'b0}};
            cur_r       <= iw'(inputs - 1);
            burst_cnt_r <= {bw{1'b0}};
        end else if (xfer_s) begin
            p_srdy_r    <= 1'b1;
            p_data_r    <= win_data_s;
            p_grant_r   <= win_idx_s;
            cur_r       <= win_idx_s;
            burst_cnt_r <= burst_next_s;
        end else if (load_s) begin
            p_srdy_r    <= 1'b0;
        end
    end

    assign p_srdy  = p_srdy_r;
    assign p_data  = p_data_r;
    assign p_grant = p_grant_r;

endmodule
